// File: rtl/bmc_acs_sched_pkg.sv
// Shared Viterbi scheduler definitions: default trellis sizing, FSM encoding,
// group-count derivation and the initial path-metric constants used by the ACS bank.
package bmc_acs_sched_pkg;

  localparam int unsigned NUM_STATES_DEF  = 64;
  localparam int unsigned NUM_BFLY_DEF    = 8;
  localparam int unsigned PM_W_DEF        = 8;
  localparam int unsigned NORM_THRESH_DEF = 192;
  localparam int unsigned STEP_W_DEF      = 16;

  // Initial metrics: state PM_INIT_STATE starts best, every other state worst.
  localparam int unsigned             PM_INIT_STATE = 0;
  localparam logic [PM_W_DEF-1:0]     PM_INIT_BEST  = '0;
  localparam logic [PM_W_DEF-1:0]     PM_INIT_WORST = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } sched_state_e;

  function automatic int unsigned num_groups(input int unsigned num_states,
                                             input int unsigned num_bfly);
    return num_states / 2 / num_bfly;
  endfunction

  function automatic int unsigned grp_width(input int unsigned groups);
    return (groups <= 1) ? 1 : $clog2(groups);
  endfunction

endpackage

// File: rtl/bmc_acs_sched_if.sv
// Scheduler bus: symbol handshake in, butterfly sequencing and step status out.
interface bmc_acs_sched_if #(
  parameter int unsigned PM_W   = 8,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned GRP_W  = 2
);
  logic              frame_start;
  logic              rx_valid;
  logic              rx_ready;
  logic [1:0]        rx_pair;
  logic [1:0]        bmc_rx_pair;
  logic [GRP_W-1:0]  bfly_group;
  logic              acs_en;
  logic              pm_init;
  logic              pm_bank_sel;
  logic [PM_W-1:0]   pm_min_in;
  logic              norm_en;
  logic [PM_W-1:0]   norm_value;
  logic              dec_valid;
  logic [STEP_W-1:0] step_cnt;

  modport master (
    output frame_start, rx_valid, rx_pair, pm_min_in,
    input  rx_ready, bmc_rx_pair, bfly_group, acs_en, pm_init, pm_bank_sel,
           norm_en, norm_value, dec_valid, step_cnt
  );

  modport slave (
    input  frame_start, rx_valid, rx_pair, pm_min_in,
    output rx_ready, bmc_rx_pair, bfly_group, acs_en, pm_init, pm_bank_sel,
           norm_en, norm_value, dec_valid, step_cnt
  );
endinterface

// File: rtl/bmc_acs_sched_pm_min_tracker.sv
// Running unsigned minimum of the per-group ACS metric minima within one trellis step.
module pm_min_tracker #(
  parameter int unsigned PM_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [PM_W-1:0] pm_min_i,
  output logic [PM_W-1:0] min_c_o
);

  logic [PM_W-1:0] min_q;
  logic [PM_W-1:0] min_d;

  // min_c_o includes the current cycle's input so the final step minimum is usable at the last edge.
  always_comb begin
    min_d = min_q;
    if (load_i) begin
      min_d = pm_min_i;
    end else if (en_i && (pm_min_i < min_q)) begin
      min_d = pm_min_i;
    end
  end

  assign min_c_o = min_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
    end else begin
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/bmc_acs_sched.sv
// BMC/ACS butterfly scheduler: sequences butterfly groups per received symbol pair,
// ping-pongs the path-metric bank and decides metric normalisation for the next step.
module bmc_acs_sched
  import bmc_acs_sched_pkg::*;
#(
  parameter int unsigned NUM_STATES     = NUM_STATES_DEF,
  parameter int unsigned NUM_BFLY_UNITS = NUM_BFLY_DEF,
  parameter int unsigned PM_W           = PM_W_DEF,
  parameter int unsigned NORM_THRESH    = NORM_THRESH_DEF,
  parameter int unsigned STEP_W         = STEP_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  bmc_acs_sched_if.slave bus
);

  localparam int unsigned      G        = num_groups(NUM_STATES, NUM_BFLY_UNITS);
  localparam int unsigned      GRP_W    = grp_width(G);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);
  localparam logic [PM_W-1:0]  THRESH   = PM_W'(NORM_THRESH);

  sched_state_e      state_q, state_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [1:0]        pair_q, pair_d;
  logic              rx_ready_q, rx_ready_d;
  logic              acs_en_q, acs_en_d;
  logic              pm_init_q, pm_init_d;
  logic              bank_q, bank_d;
  logic              norm_en_q, norm_en_d;
  logic [PM_W-1:0]   norm_val_q, norm_val_d;
  logic              dec_valid_q, dec_valid_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [PM_W-1:0]   min_c;
  logic              grp_last;

  pm_min_tracker #(.PM_W(PM_W)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (acs_en_q && (grp_q == '0)),
    .en_i     (acs_en_q),
    .pm_min_i (bus.pm_min_in),
    .min_c_o  (min_c)
  );

  assign grp_last = (grp_q == GRP_LAST);

  // Next-state and registered-output decode; frame_start overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    grp_d       = '0;
    pair_d      = pair_q;
    bank_d      = bank_q;
    norm_en_d   = norm_en_q;
    norm_val_d  = norm_val_q;
    step_d      = step_q;
    dec_valid_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (grp_last) state_d = ST_WAIT;
        else          grp_d   = grp_q + GRP_W'(1);
      end
      ST_WAIT: begin
        if (bus.rx_valid && rx_ready_q) begin
          state_d = ST_RUN;
          pair_d  = bus.rx_pair;
        end
      end
      ST_RUN: begin
        if (grp_last) begin
          state_d     = ST_WAIT;
          dec_valid_d = 1'b1;
          bank_d      = ~bank_q;
          step_d      = (step_q == '1) ? step_q : step_q + STEP_W'(1);
          if (min_c >= THRESH) begin
            norm_en_d  = 1'b1;
            norm_val_d = min_c;
          end else begin
            norm_en_d  = 1'b0;
            norm_val_d = '0;
          end
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end
      default: state_d = state_q;
    endcase

    if (bus.frame_start) begin
      state_d     = ST_INIT;
      grp_d       = '0;
      pair_d      = pair_q;
      bank_d      = bank_q;
      step_d      = '0;
      norm_en_d   = 1'b0;
      norm_val_d  = '0;
      dec_valid_d = 1'b0;
    end

    rx_ready_d = (state_d == ST_WAIT);
    acs_en_d   = (state_d == ST_RUN);
    pm_init_d  = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grp_q       <= '0;
      pair_q      <= '0;
      rx_ready_q  <= 1'b0;
      acs_en_q    <= 1'b0;
      pm_init_q   <= 1'b0;
      bank_q      <= 1'b0;
      norm_en_q   <= 1'b0;
      norm_val_q  <= '0;
      dec_valid_q <= 1'b0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      pair_q      <= pair_d;
      rx_ready_q  <= rx_ready_d;
      acs_en_q    <= acs_en_d;
      pm_init_q   <= pm_init_d;
      bank_q      <= bank_d;
      norm_en_q   <= norm_en_d;
      norm_val_q  <= norm_val_d;
      dec_valid_q <= dec_valid_d;
      step_q      <= step_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.bmc_rx_pair = pair_q;
  assign bus.bfly_group  = grp_q;
  assign bus.acs_en      = acs_en_q;
  assign bus.pm_init     = pm_init_q;
  assign bus.pm_bank_sel = bank_q;
  assign bus.norm_en     = norm_en_q;
  assign bus.norm_value  = norm_val_q;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.step_cnt    = step_q;

endmodule

// File: tb/tb_bmc_acs_sched.sv
// Directed bench for bmc_acs_sched: per-step expectations queued at handshake, checked on dec_valid.
module tb_bmc_acs_sched;
  import bmc_acs_sched_pkg::*;

  localparam int unsigned NS   = 64;
  localparam int unsigned NB   = 8;
  localparam int unsigned PW   = 8;
  localparam int unsigned ST_W = 4;
  localparam int unsigned TH   = 192;
  localparam int unsigned G    = 4;
  localparam int unsigned GW   = 2;

  typedef struct packed {
    logic [1:0]      pair;
    logic [ST_W-1:0] step;
    logic            bank;
    logic            nen;
    logic [PW-1:0]   nval;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmc_acs_sched_if #(.PM_W(PW), .STEP_W(ST_W), .GRP_W(GW)) bus ();

  bmc_acs_sched #(
    .NUM_STATES(NS), .NUM_BFLY_UNITS(NB), .PM_W(PW), .NORM_THRESH(TH), .STEP_W(ST_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hs_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [ST_W-1:0] m_step = '0;
  logic            m_bank = 1'b0;
  logic            m_nen  = 1'b0;
  logic [PW-1:0]   m_nval = '0;
  logic [4*PW-1:0] mins;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] v);
    return (v == '1) ? v : v + ST_W'(1);
  endfunction

  // During RUN the front entry describes the step in flight; dec_valid retires it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.acs_en === 1'b1) begin
        chk("sb_has_run", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("bmc_rx_pair_run", 32'(bus.bmc_rx_pair), 32'(sb[0].pair));
          chk("norm_en_run", 32'(bus.norm_en), 32'(sb[0].nen));
          chk("norm_value_run", 32'(bus.norm_value), 32'(sb[0].nval));
        end
      end
      if (bus.dec_valid === 1'b1) begin
        chk("sb_has_dec", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("step_cnt_dec", 32'(bus.step_cnt), 32'(mon_e.step));
          chk("bank_dec", 32'(bus.pm_bank_sel), 32'(mon_e.bank));
          chk("bmc_rx_pair_dec", 32'(bus.bmc_rx_pair), 32'(mon_e.pair));
        end
      end
    end
  end

  task automatic check_init();
    m_step = '0;
    m_nen  = 1'b0;
    m_nval = '0;
    for (int i = 0; i < int'(G); i++) begin
      chk("init_pm_init", 32'(bus.pm_init), 32'd1);
      chk("init_grp", 32'(bus.bfly_group), 32'(i));
      chk("init_acs_en", 32'(bus.acs_en), 32'd0);
      chk("init_rx_ready", 32'(bus.rx_ready), 32'd0);
      chk("init_dec_valid", 32'(bus.dec_valid), 32'd0);
      chk("init_step", 32'(bus.step_cnt), 32'd0);
      chk("init_norm_en", 32'(bus.norm_en), 32'd0);
      chk("init_norm_val", 32'(bus.norm_value), 32'd0);
      chk("init_bank", 32'(bus.pm_bank_sel), 32'(m_bank));
      tick();
    end
    chk("post_init_pm_init", 32'(bus.pm_init), 32'd0);
    chk("post_init_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("post_init_grp", 32'(bus.bfly_group), 32'd0);
  endtask

  task automatic pulse_frame(input bit with_rx);
    bus.frame_start = 1'b1;
    if (with_rx) begin
      bus.rx_valid = 1'b1;
      bus.rx_pair  = 2'b01;
    end
    tick();
    bus.frame_start = 1'b0;
    bus.rx_valid    = 1'b0;
    check_init();
  endtask

  task automatic run_step(input logic [1:0] pair, input logic [4*PW-1:0] mv,
                          input bit keep_valid, input bit poke);
    int guard;
    exp_t e;
    logic [PW-1:0] mn;
    guard = 0;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    if (bus.rx_ready === 1'b1) begin
      bus.rx_valid = 1'b1;
      bus.rx_pair  = pair;
      e.pair = pair;
      e.step = sat_inc(m_step);
      e.bank = ~m_bank;
      e.nen  = m_nen;
      e.nval = m_nval;
      sb.push_back(e);
      hs_cyc = cyc;
      tick();
      chk("dec_valid_pulse", 32'(bus.dec_valid), 32'd0);
      if (!keep_valid) bus.rx_valid = 1'b0;
      mn = '1;
      for (int i = 0; i < int'(G); i++) begin
        chk("run_acs_en", 32'(bus.acs_en), 32'd1);
        chk("run_grp", 32'(bus.bfly_group), 32'(i));
        chk("run_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("run_pm_init", 32'(bus.pm_init), 32'd0);
        bus.pm_min_in = mv[PW*i +: PW];
        if (mv[PW*i +: PW] < mn) mn = mv[PW*i +: PW];
        if (poke) begin
          bus.rx_valid = (i == 1);
          bus.rx_pair  = ~pair;
        end
        tick();
      end
      m_step = sat_inc(m_step);
      m_bank = ~m_bank;
      m_nen  = (mn >= PW'(TH));
      m_nval = m_nen ? mn : '0;
      chk("end_dec_valid", 32'(bus.dec_valid), 32'd1);
      chk("end_acs_en", 32'(bus.acs_en), 32'd0);
      chk("end_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("end_grp", 32'(bus.bfly_group), 32'd0);
      chk("norm_en_next", 32'(bus.norm_en), 32'(m_nen));
      chk("norm_value_next", 32'(bus.norm_value), 32'(m_nval));
    end
  endtask

  initial begin
    int prev;
    bus.frame_start = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_pair     = 2'b00;
    bus.pm_min_in   = '0;

    // Reset values
    tick(); tick();
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_pair", 32'(bus.bmc_rx_pair), 32'd0);
    chk("rst_grp", 32'(bus.bfly_group), 32'd0);
    chk("rst_acs_en", 32'(bus.acs_en), 32'd0);
    chk("rst_pm_init", 32'(bus.pm_init), 32'd0);
    chk("rst_bank", 32'(bus.pm_bank_sel), 32'd0);
    chk("rst_norm_en", 32'(bus.norm_en), 32'd0);
    chk("rst_norm_val", 32'(bus.norm_value), 32'd0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_step", 32'(bus.step_cnt), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("idle_pm_init", 32'(bus.pm_init), 32'd0);

    pulse_frame(1'b0);

    // Single step
    run_step(2'b10, {8'd25, 8'd30, 8'd12, 8'd40}, 1'b0, 1'b0);
    chk("single_step_cnt", 32'(bus.step_cnt), 32'd1);
    chk("single_bank", 32'(bus.pm_bank_sel), 32'd1);
    chk("single_norm_en", 32'(bus.norm_en), 32'd0);

    // Normalisation on, then off; rx_valid poked during RUN must be ignored
    run_step(2'b01, {8'd199, 8'd210, 8'd195, 8'd200}, 1'b0, 1'b0);
    chk("norm_on_en", 32'(bus.norm_en), 32'd1);
    chk("norm_on_val", 32'(bus.norm_value), 32'd195);
    run_step(2'b11, {8'd80, 8'd70, 8'd60, 8'd50}, 1'b0, 1'b1);
    chk("norm_off_en", 32'(bus.norm_en), 32'd0);
    chk("norm_off_val", 32'(bus.norm_value), 32'd0);
    run_step(2'b00, {4{8'd100}}, 1'b0, 1'b0);

    // Abort on the third RUN cycle after a normalising step
    run_step(2'b01, {4{8'd220}}, 1'b0, 1'b0);
    chk("pre_abort_norm", 32'(bus.norm_en), 32'd1);
    chk("pre_abort_ready", 32'(bus.rx_ready), 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_pair  = 2'b11;
    mon_e.pair = 2'b11;
    mon_e.step = sat_inc(m_step);
    mon_e.bank = ~m_bank;
    mon_e.nen  = m_nen;
    mon_e.nval = m_nval;
    sb.push_back(mon_e);
    tick();
    bus.rx_valid = 1'b0;
    tick(); tick();
    chk("abort_grp", 32'(bus.bfly_group), 32'd2);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    sb.delete();
    check_init();
    chk("abort_step", 32'(bus.step_cnt), 32'd0);

    // Back-to-back with rx_valid held high
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < int'(G); k++) mins[PW*k +: PW] = PW'($urandom_range(0, 255));
      prev = hs_cyc;
      run_step(2'(s), mins, 1'b1, 1'b0);
      if (s > 0) chk("b2b_spacing", 32'(hs_cyc - prev), 32'(G + 1));
    end
    bus.rx_valid = 1'b0;
    chk("b2b_step", 32'(bus.step_cnt), 32'd10);
    chk("b2b_bank", 32'(bus.pm_bank_sel), 32'(m_bank));

    // frame_start beats a simultaneous handshake; then saturate the step counter
    pulse_frame(1'b1);
    for (int s = 0; s < 17; s++) begin
      run_step(2'(s + 1), {8'd9, 8'd8, 8'd7, 8'd6}, 1'b0, 1'b0);
    end
    chk("sat_step", 32'(bus.step_cnt), 32'd15);
    tick(); tick();
    chk("final_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
